adder_rr_arbiter: RTL and testbench

Shares one 64-bit parallel-prefix adder between four independent requesters. A round-robin arbiter accepts at most one operand pair per cycle, drives the shared adder, and registers the sum into a one-entry output stage with a valid/ready handshake. It sits between the four client ports of the 4-way adder top level and the single adder instance.

---
 rtl/adder_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: four requesters share one 64-bit prefix adder.
// Round-robin grant, one accept per cycle, one-entry valid/ready result.
//
// Ports:
//   clk, rst             : rising-edge clock, async active-high reset
//   req_valid/req_ready  : per-requester handshake (ready one-hot or 0)
//   req_sayi1/req_sayi2  : operands, requester k at [64k+63:64k]
//   res_valid/res_ready  : result handshake
//   res_toplam, res_id   : registered sum and owning requester
//   op_count             : accepted ops (only with ADDER_ARB_OPCNT_EN)
//
// Build option: define ADDER_ARB_OPCNT_EN to add the op_count port.

module adder_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [64*N_REQ-1:0] req_sayi1,
  input  logic [64*N_REQ-1:0] req_sayi2,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [63:0]        res_toplam,
  output logic [1:0]         res_id
`ifdef ADDER_ARB_OPCNT_EN
  ,
  output logic [CNT_W-1:0]   op_count
`endif
);

  if (N_REQ != 4 || CNT_W < 1) begin : g_cfg_err
    $error("adder_rr_arbiter: N_REQ must be 4, CNT_W >= 1");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  last;
  logic [1:0]  gnt;
  logic        found;
  logic        can_accept;
  logic        accept;
  logic [63:0] opa;
  logic [63:0] opb;
  logic [63:0] sum;

  assign res_valid  = (state_q == FULL);
  assign can_accept = (state_q == EMPTY) | res_ready;

  // Search starts one past the last winner and wraps.
  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    found = 1'b0;
    gnt   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // rst gates ready so nothing looks accepted while in reset.
  always_comb begin
    req_ready = '0;
    if (found && can_accept && !rst)
      req_ready[gnt] = 1'b1;
  end

  assign accept = |req_ready;

  always_comb begin
    opa = '0;
    opb = '0;
    unique case (gnt)
      2'd0: begin
        opa = req_sayi1[63:0];
        opb = req_sayi2[63:0];
      end
      2'd1: begin
        opa = req_sayi1[127:64];
        opb = req_sayi2[127:64];
      end
      2'd2: begin
        opa = req_sayi1[191:128];
        opb = req_sayi2[191:128];
      end
      2'd3: begin
        opa = req_sayi1[255:192];
        opb = req_sayi2[255:192];
      end
      default: begin
        opa = '0;
        opb = '0;
      end
    endcase
  end

  // Kogge-Stone prefix carry: six doubling levels over 64 bits.
  // Zero fill on the shifts models a carry-in of 0.
  always_comb begin
    logic [63:0] g;
    logic [63:0] p;
    g = opa & opb;
    p = opa ^ opb;
    for (int l = 0; l < 6; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & (p << (1 << l));
    end
    sum = (opa ^ opb) ^ {g[62:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = FULL;
    else if (state_q == FULL && res_ready)
      state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_toplam <= '0;
      res_id     <= '0;
      last       <= 2'd3;
    end else if (accept) begin
      res_toplam <= sum;
      res_id     <= gnt;
      last       <= gnt;
    end
  end

`ifdef ADDER_ARB_OPCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      op_count <= '0;
    else if (accept)
      op_count <= op_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed bench with a result scoreboard.
// Expected sums and grants come from a small reference model.

module tb_adder_rr_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] sum;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [3:0]   rv;
  logic [3:0]   req_ready;
  logic [255:0] sayi1;
  logic [255:0] sayi2;
  logic         res_valid;
  logic         rr;
  logic [63:0]  res_toplam;
  logic [1:0]   res_id;
`ifdef ADDER_ARB_OPCNT_EN
  logic [3:0]   op_count;
`endif

  logic [63:0] a [4];
  logic [63:0] b [4];

  exp_t q[$];
  int   m_last;
  bit   m_full;
  int   m_cnt;
  int   errors;
  int   checks;

  assign sayi1 = {a[3], a[2], a[1], a[0]};
  assign sayi2 = {b[3], b[2], b[1], b[0]};

  adder_rr_arbiter #(
    .N_REQ(4),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv),
    .req_ready (req_ready),
    .req_sayi1 (sayi1),
    .req_sayi2 (sayi2),
    .res_valid (res_valid),
    .res_ready (rr),
    .res_toplam(res_toplam),
    .res_id    (res_id)
`ifdef ADDER_ARB_OPCNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = 3;
    m_full = 0;
    m_cnt  = 0;
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < 4; k++) begin
      a[k] = {$urandom, $urandom};
      b[k] = {$urandom, $urandom};
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step(input string tag);
    int   g;
    bit   acc;
    exp_t e;
    #1;
    g = -1;
    for (int i = 1; i <= 4; i++) begin
      int idx;
      idx = (m_last + i) % 4;
      if (g < 0 && rv[idx]) g = idx;
    end
    acc = (g >= 0) && (!m_full || rr);
    check({tag, ".req_ready"}, 64'(req_ready),
          acc ? 64'(4'b0001 << g) : 64'd0);
    @(posedge clk);
    if (m_full && rr && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      e.id  = 2'(g);
      e.sum = a[g] + b[g];
      q.push_back(e);
      m_last = g;
      m_full = 1;
      m_cnt  = (m_cnt + 1) % 16;
    end else if (rr) begin
      m_full = 0;
    end
    @(negedge clk);
    check({tag, ".res_valid"}, 64'(res_valid), 64'(m_full));
    if (m_full && q.size() > 0) begin
      check({tag, ".res_toplam"}, res_toplam, q[0].sum);
      check({tag, ".res_id"}, 64'(res_id), 64'(q[0].id));
    end
`ifdef ADDER_ARB_OPCNT_EN
    check({tag, ".op_count"}, 64'(op_count), 64'(m_cnt));
`endif
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    rst = 1'b1;
    rr  = 1'b1;
    rv  = 4'hF;
    randomize_ops();

    // Requests held through reset must not be granted.
    @(negedge clk);
    @(negedge clk);
    check("rst.res_valid", 64'(res_valid), 64'd0);
    check("rst.res_toplam", res_toplam, 64'd0);
    check("rst.res_id", 64'(res_id), 64'd0);
    check("rst.req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // Requester 2 alone: 5 + 7.
    rv   = 4'b0100;
    a[2] = 64'h5;
    b[2] = 64'h7;
    step("r2_add");
    check("r2_add.sum", res_toplam, 64'hC);

    // Requester 0 wraps to zero.
    rv   = 4'b0001;
    a[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    b[0] = 64'h1;
    step("wrap");
    check("wrap.sum", res_toplam, 64'h0);

    // Drain with nothing requesting.
    rv = 4'b0000;
    step("drain");

    // All four from reset: 0,1,2,3,0,...
    pulse_reset();
    rv = 4'hF;
    for (int n = 0; n < 8; n++) begin
      randomize_ops();
      step("rr_all");
      check("rr_all.order", 64'(res_id), 64'(n % 4));
    end

    // Backpressure for three cycles while full.
    rr = 1'b0;
    for (int n = 0; n < 3; n++) begin
      randomize_ops();
      step("bp_hold");
    end
    rr = 1'b1;
    step("bp_release");

    // Mixed sparse requests with random backpressure.
    for (int n = 0; n < 20; n++) begin
      rv = 4'($urandom);
      rr = 1'($urandom);
      randomize_ops();
      step("mixed");
    end

    // Async reset mid-cycle while full and stalled.
    rv = 4'hF;
    rr = 1'b1;
    randomize_ops();
    step("pre_rst");
    rr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async.res_valid", 64'(res_valid), 64'd0);
    check("async.res_toplam", res_toplam, 64'd0);
    check("async.req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    rr  = 1'b1;
    randomize_ops();
    step("post_rst");
    check("post_rst.first", 64'(res_id), 64'd0);

    // Seventeen accepts from reset.
    pulse_reset();
    rv = 4'hF;
    for (int n = 0; n < 17; n++) begin
      randomize_ops();
      step("cnt_run");
    end
`ifdef ADDER_ARB_OPCNT_EN
    check("cnt_run.op_count17", 64'(op_count), 64'd1);
`endif

    rv = 4'h0;
    step("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
